// File: rtl/reg_unit_pkg.sv
// ============================================================================
//  Module      : reg_unit_pkg
//  Description : Shared constants, operand use codes and unit codes for the
//                scoreboarded register unit.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package reg_unit_pkg;

    localparam int DEF_DATA_W   = 64;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_REG_AW   = 5;
    localparam int DEF_NUM_SRC  = 3;
    localparam int DEF_NUM_WB   = 2;
    localparam int DEF_CNT_W    = 2;
    localparam int DEF_TAG_W    = 32;

    typedef enum logic [1:0] {
        USE_IMM       = 2'd0,
        USE_READ      = 2'd1,
        USE_WRITE     = 2'd2,
        USE_READWRITE = 2'd3
    } use_code_e;

    typedef enum logic [2:0] {
        FU_ALU = 3'd0,
        FU_MUL = 3'd1,
        FU_DIV = 3'd2,
        FU_LSU = 3'd3,
        FU_BRU = 3'd4
    } fu_code_e;

    // Largest number of writes a single register may have in flight.
    function automatic int cnt_max(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pending_counter_bank.sv
// ============================================================================
//  Module      : pending_counter_bank
//  Description : Per-register pending-write counters with one issue increment,
//                NUM_WB writeback decrements and zero/saturation/last flags.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pending_counter_bank
    import reg_unit_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int REG_AW   = DEF_REG_AW,
    parameter int NUM_WB   = DEF_NUM_WB,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     inc_en,
    input  logic [REG_AW-1:0]        inc_addr,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*REG_AW-1:0] wb_addr,
    output logic [NUM_REGS-1:0]      zero,
    output logic [NUM_REGS-1:0]      sat,
    output logic [NUM_REGS-1:0]      last,
    output logic                     underflow
);

    localparam int CNT_MAX = cnt_max(CNT_W);

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_next;

        // Several ports hitting a register with a small count clamp at zero.
        always_comb begin
            int n;
            n = int'(r_cnt);
            if (inc_en && (inc_addr == REG_AW'(r))) begin
                n = n + 1;
            end
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_valid[p] && (wb_addr[p*REG_AW +: REG_AW] == REG_AW'(r)) && (r_cnt != '0)) begin
                    n = n - 1;
                end
            end
            if (n < 0) begin
                n = 0;
            end else if (n > CNT_MAX) begin
                n = CNT_MAX;
            end
            w_cnt_next = CNT_W'(n);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_next;
            end
        end

        assign zero[r] = (r_cnt == '0);
        assign sat[r]  = (r_cnt == CNT_W'(CNT_MAX));
        assign last[r] = (r_cnt == CNT_W'(1));
    end

    always_comb begin
        underflow = 1'b0;
        for (int p = 0; p < NUM_WB; p++) begin
            if (wb_valid[p] && zero[wb_addr[p*REG_AW +: REG_AW]]) begin
                underflow = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/scoreboard_reg_unit.sv
// ============================================================================
//  Module      : scoreboard_reg_unit
//  Description : Scoreboarded register file between issue and the functional
//                units. Optional macro SCOREBOARD_REG_UNIT_BYPASS_EN adds a
//                writeback-to-operand bypass for the last pending write.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module scoreboard_reg_unit
    import reg_unit_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int REG_AW   = DEF_REG_AW,
    parameter int NUM_SRC  = DEF_NUM_SRC,
    parameter int NUM_WB   = DEF_NUM_WB,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int TAG_W    = DEF_TAG_W
) (
    input  logic                      clock_i,
    input  logic                      reset_ni,
    input  logic                      issue_valid_i,
    output logic                      issue_ready_o,
    input  logic [NUM_SRC-1:0]        src_en_i,
    input  logic [NUM_SRC*REG_AW-1:0] src_addr_i,
    input  logic [NUM_SRC-1:0]        src_zero_i,
    input  logic                      dst_en_i,
    input  logic [REG_AW-1:0]         dst_addr_i,
    input  logic [TAG_W-1:0]          tag_i,
    output logic                      disp_valid_o,
    input  logic                      disp_ready_i,
    output logic [NUM_SRC*DATA_W-1:0] operand_o,
    output logic [NUM_SRC-1:0]        src_en_o,
    output logic                      dst_en_o,
    output logic [REG_AW-1:0]         dst_addr_o,
    output logic [TAG_W-1:0]          tag_o,
    input  logic [NUM_WB-1:0]         wb_valid_i,
    input  logic [NUM_WB*REG_AW-1:0]  wb_addr_i,
    input  logic [NUM_WB*DATA_W-1:0]  wb_data_i,
    input  logic [REG_AW-1:0]         dbg_addr_i,
    output logic [DATA_W-1:0]         dbg_data_o,
    output logic                      wb_underflow_o
);

    logic [1:0]                r_rst_sync;
    logic                      w_rst_n;
    logic [DATA_W-1:0]         r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]       w_zero;
    logic [NUM_REGS-1:0]       w_sat;
    logic [NUM_REGS-1:0]       w_last;
    logic                      w_underflow;
    logic [NUM_SRC-1:0]        w_src_haz;
    logic [NUM_SRC*DATA_W-1:0] w_operand;
    logic                      w_dst_sat;
    logic                      w_stage_free;
    logic                      w_accept;

    logic                      r_disp_valid;
    logic [NUM_SRC*DATA_W-1:0] r_operand;
    logic [NUM_SRC-1:0]        r_src_en;
    logic                      r_dst_en;
    logic [REG_AW-1:0]         r_dst_addr;
    logic [TAG_W-1:0]          r_tag;
    logic [DATA_W-1:0]         r_dbg_data;
    logic                      r_wb_underflow;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    pending_counter_bank #(
        .NUM_REGS (NUM_REGS),
        .REG_AW   (REG_AW),
        .NUM_WB   (NUM_WB),
        .CNT_W    (CNT_W)
    ) u_cnt_bank (
        .clk       (clock_i),
        .rst_n     (w_rst_n),
        .inc_en    (w_accept && dst_en_i),
        .inc_addr  (dst_addr_i),
        .wb_valid  (wb_valid_i),
        .wb_addr   (wb_addr_i),
        .zero      (w_zero),
        .sat       (w_sat),
        .last      (w_last),
        .underflow (w_underflow)
    );

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        logic [REG_AW-1:0] w_addr;
        logic              w_used;

        assign w_addr = src_addr_i[k*REG_AW +: REG_AW];
        assign w_used = src_en_i[k] && !(src_zero_i[k] && (w_addr == '0));

`ifdef SCOREBOARD_REG_UNIT_BYPASS_EN
        logic              w_wb_hit;
        logic [DATA_W-1:0] w_wb_data;
        logic              w_bypass;

        // Highest-index port wins, matching the register file write order.
        always_comb begin
            w_wb_hit  = 1'b0;
            w_wb_data = '0;
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_valid_i[p] && (wb_addr_i[p*REG_AW +: REG_AW] == w_addr)) begin
                    w_wb_hit  = 1'b1;
                    w_wb_data = wb_data_i[p*DATA_W +: DATA_W];
                end
            end
        end

        assign w_bypass     = w_used && w_last[w_addr] && w_wb_hit;
        assign w_src_haz[k] = w_used && !w_zero[w_addr] && !w_bypass;
        assign w_operand[k*DATA_W +: DATA_W] =
            !w_used ? '0 : (w_bypass ? w_wb_data : r_regs[w_addr]);
`else
        assign w_src_haz[k] = w_used && !w_zero[w_addr];
        assign w_operand[k*DATA_W +: DATA_W] = w_used ? r_regs[w_addr] : '0;
`endif
    end

`ifndef SCOREBOARD_REG_UNIT_BYPASS_EN
    logic w_unused_last;
    assign w_unused_last = ^w_last;
`endif

    assign w_dst_sat     = dst_en_i && w_sat[dst_addr_i];
    assign w_stage_free  = !r_disp_valid || disp_ready_i;
    assign issue_ready_o = w_rst_n && w_stage_free && !(|w_src_haz) && !w_dst_sat;
    assign w_accept      = issue_valid_i && issue_ready_o;

    always_ff @(posedge clock_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_disp_valid <= 1'b0;
            r_operand    <= '0;
            r_src_en     <= '0;
            r_dst_en     <= 1'b0;
            r_dst_addr   <= '0;
            r_tag        <= '0;
        end else if (w_accept) begin
            r_disp_valid <= 1'b1;
            r_operand    <= w_operand;
            r_src_en     <= src_en_i;
            r_dst_en     <= dst_en_i;
            r_dst_addr   <= dst_addr_i;
            r_tag        <= tag_i;
        end else if (disp_ready_i) begin
            r_disp_valid <= 1'b0;
        end
    end

    // Later ports overwrite earlier ones when addresses collide.
    always_ff @(posedge clock_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_valid_i[p]) begin
                    r_regs[wb_addr_i[p*REG_AW +: REG_AW]] <= wb_data_i[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clock_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_dbg_data     <= '0;
            r_wb_underflow <= 1'b0;
        end else begin
            r_dbg_data     <= r_regs[dbg_addr_i];
            r_wb_underflow <= r_wb_underflow || w_underflow;
        end
    end

    assign disp_valid_o   = r_disp_valid;
    assign operand_o      = r_operand;
    assign src_en_o       = r_src_en;
    assign dst_en_o       = r_dst_en;
    assign dst_addr_o     = r_dst_addr;
    assign tag_o          = r_tag;
    assign dbg_data_o     = r_dbg_data;
    assign wb_underflow_o = r_wb_underflow;

endmodule

`default_nettype wire

// File: tb/tb_scoreboard_reg_unit.sv
// ============================================================================
//  Module      : tb_scoreboard_reg_unit
//  Description : Directed and random stimulus for scoreboard_reg_unit against
//                an array-based reference model of the scoreboard rules.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_scoreboard_reg_unit;

    localparam int DATA_W   = 64;
    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_SRC  = 3;
    localparam int NUM_WB   = 2;
    localparam int CNT_W    = 2;
    localparam int TAG_W    = 32;
    localparam int MAXC     = (1 << CNT_W) - 1;
`ifdef SCOREBOARD_REG_UNIT_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_ni = 1'b0;
    always #5 clk = ~clk;

    logic                                  iv;
    logic [NUM_SRC-1:0]                    sen;
    logic [NUM_SRC-1:0]                    szero;
    logic [NUM_SRC-1:0][REG_AW-1:0]        saddr;
    logic                                  den;
    logic [REG_AW-1:0]                     daddr;
    logic [TAG_W-1:0]                      tag;
    logic                                  dr;
    logic [NUM_WB-1:0]                     wbv;
    logic [NUM_WB-1:0][REG_AW-1:0]         wba;
    logic [NUM_WB-1:0][DATA_W-1:0]         wbd;
    logic [REG_AW-1:0]                     dbga;

    logic                      issue_ready;
    logic                      disp_valid;
    logic [NUM_SRC*DATA_W-1:0] operand;
    logic [NUM_SRC-1:0]        src_en_q;
    logic                      dst_en_q;
    logic [REG_AW-1:0]         dst_addr_q;
    logic [TAG_W-1:0]          tag_q;
    logic [DATA_W-1:0]         dbg_data;
    logic                      underflow;

    scoreboard_reg_unit #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .NUM_SRC(NUM_SRC),
        .NUM_WB(NUM_WB), .CNT_W(CNT_W), .TAG_W(TAG_W)
    ) dut (
        .clock_i        (clk),
        .reset_ni       (reset_ni),
        .issue_valid_i  (iv),
        .issue_ready_o  (issue_ready),
        .src_en_i       (sen),
        .src_addr_i     (saddr),
        .src_zero_i     (szero),
        .dst_en_i       (den),
        .dst_addr_i     (daddr),
        .tag_i          (tag),
        .disp_valid_o   (disp_valid),
        .disp_ready_i   (dr),
        .operand_o      (operand),
        .src_en_o       (src_en_q),
        .dst_en_o       (dst_en_q),
        .dst_addr_o     (dst_addr_q),
        .tag_o          (tag_q),
        .wb_valid_i     (wbv),
        .wb_addr_i      (wba),
        .wb_data_i      (wbd),
        .dbg_addr_i     (dbga),
        .dbg_data_o     (dbg_data),
        .wb_underflow_o (underflow)
    );

    // Reference model state
    logic [DATA_W-1:0] m_regs [NUM_REGS];
    int                m_cnt  [NUM_REGS];
    logic [DATA_W-1:0] m_op   [NUM_SRC];
    bit                m_uf, m_dv, m_den;
    logic [NUM_SRC-1:0] m_sen;
    logic [REG_AW-1:0] m_daddr;
    logic [TAG_W-1:0]  m_tag;
    logic [DATA_W-1:0] m_dbg;

    int   checks = 0;
    int   errors = 0;
    logic obs_ready;

    task automatic chk(input string name, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NUM_REGS; r++) begin
            m_regs[r] = '0;
            m_cnt[r]  = 0;
        end
        for (int k = 0; k < NUM_SRC; k++) m_op[k] = '0;
        m_uf = 0; m_dv = 0; m_den = 0;
        m_sen = '0; m_daddr = '0; m_tag = '0; m_dbg = '0;
    endtask

    task automatic idle();
        iv = 0; sen = '0; szero = '0; saddr = '0; den = 0; daddr = '0; tag = '0;
        dr = 1; wbv = '0; wba = '0; wbd = '0; dbga = '0;
    endtask

    function automatic bit used(input int k);
        return sen[k] && !(szero[k] && saddr[k] == '0);
    endfunction

    function automatic bit bypass_ok(input int k);
        bit hit = 0;
        for (int p = 0; p < NUM_WB; p++)
            if (wbv[p] && wba[p] == saddr[k]) hit = 1;
        return BYPASS && used(k) && m_cnt[saddr[k]] == 1 && hit;
    endfunction

    function automatic logic [DATA_W-1:0] opval(input int k);
        logic [DATA_W-1:0] v = '0;
        if (used(k)) begin
            v = m_regs[saddr[k]];
            if (bypass_ok(k))
                for (int p = 0; p < NUM_WB; p++)
                    if (wbv[p] && wba[p] == saddr[k]) v = wbd[p];
        end
        return v;
    endfunction

    function automatic bit model_ready();
        bit ok = !m_dv || dr;
        if (den && m_cnt[daddr] == MAXC) ok = 0;
        for (int k = 0; k < NUM_SRC; k++)
            if (used(k) && m_cnt[saddr[k]] != 0 && !bypass_ok(k)) ok = 0;
        return ok;
    endfunction

    task automatic model_edge(input bit rdy);
        int cnt_pre [NUM_REGS];
        bit acc = iv && rdy;
        m_dbg = m_regs[dbga];
        if (acc) begin
            m_dv = 1;
            for (int k = 0; k < NUM_SRC; k++) m_op[k] = opval(k);
            m_sen = sen; m_den = den; m_daddr = daddr; m_tag = tag;
        end else if (dr) begin
            m_dv = 0;
        end
        cnt_pre = m_cnt;
        if (acc && den) m_cnt[daddr]++;
        for (int p = 0; p < NUM_WB; p++) begin
            if (wbv[p]) begin
                if (cnt_pre[wba[p]] > 0) m_cnt[wba[p]]--;
                else m_uf = 1;
                m_regs[wba[p]] = wbd[p];
            end
        end
        for (int r = 0; r < NUM_REGS; r++)
            if (m_cnt[r] < 0) m_cnt[r] = 0;
    endtask

    // One clock: inputs already driven after the falling edge.
    task automatic tick();
        bit exp_rdy;
        #1;
        exp_rdy   = model_ready();
        obs_ready = issue_ready;
        chk("issue_ready", issue_ready, exp_rdy);
        @(posedge clk);
        model_edge(exp_rdy);
        #1;
        chk("disp_valid", disp_valid, m_dv);
        if (m_dv) begin
            for (int k = 0; k < NUM_SRC; k++)
                chk($sformatf("operand%0d", k), operand[k*DATA_W +: DATA_W], m_op[k]);
            chk("src_en_o", src_en_q, m_sen);
            chk("dst_en_o", dst_en_q, m_den);
            chk("dst_addr_o", dst_addr_q, m_daddr);
            chk("tag_o", tag_q, m_tag);
        end
        chk("dbg_data", dbg_data, m_dbg);
        chk("wb_underflow", underflow, m_uf);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_ni = 0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_ni = 1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        do_reset();
        chk("reset_disp_valid", disp_valid, 0);
        chk("reset_operand0", operand[DATA_W-1:0], 0);
        chk("reset_tag", tag_q, 0);
        chk("reset_dbg", dbg_data, 0);
        chk("reset_underflow", underflow, 0);
        chk("reset_ready", issue_ready, 1);

        // RAW: src r3 / dst r5, then r5 source stalls
        iv = 1; sen = 3'b001; saddr[0] = 5'd3; den = 1; daddr = 5'd5; tag = 32'hA5A5_0001;
        tick();
        chk("first_dispatch_valid", disp_valid, 1);
        den = 0; saddr[0] = 5'd5; tag = 32'hA5A5_0002;
        tick();
        chk("raw_stall", obs_ready, 0);
        wbv = 2'b01; wba[0] = 5'd5; wbd[0] = 64'hDEAD;
        tick();
        chk("raw_same_cycle_wb", obs_ready, BYPASS);
        wbv = '0;
        tick();
        chk("raw_after_wb_ready", obs_ready, 1);
        chk("raw_operand", operand[DATA_W-1:0], 64'hDEAD);

        // WAW saturation on r7
        idle(); iv = 1; den = 1; daddr = 5'd7;
        repeat (3) begin
            tick();
            chk("waw_accept", obs_ready, 1);
        end
        tick();
        chk("waw_saturated", obs_ready, 0);
        wbv = 2'b01; wba[0] = 5'd7; wbd[0] = 64'h7;
        tick();
        wbv = '0;
        tick();
        chk("waw_fourth_accept", obs_ready, 1);
        iv = 0; den = 0; wbv = 2'b01;
        repeat (2) tick();
        iv = 1; sen = 3'b001; saddr[0] = 5'd7; wbv = '0;
        tick();
        chk("waw_still_pending", obs_ready, 0);
        iv = 0; wbv = 2'b01;
        tick();
        iv = 1; wbv = '0;
        tick();
        chk("waw_drained", obs_ready, 1);
        chk("waw_no_underflow", underflow, 0);

        // Back-pressure hold
        idle(); iv = 1; tag = 32'h1234;
        tick();
        tag = 32'h5678; dr = 0;
        repeat (4) begin
            tick();
            chk("hold_ready", obs_ready, 0);
            chk("hold_tag", tag_q, 32'h1234);
        end
        dr = 1;
        tick();
        chk("release_tag", tag_q, 32'h5678);

        // Zero-forced r0 while r0 is pending and holds a nonzero value
        idle(); iv = 1; den = 1; daddr = 5'd0;
        repeat (2) tick();
        iv = 0; den = 0; wbv = 2'b01; wba[0] = 5'd0; wbd[0] = 64'h55;
        tick();
        iv = 1; wbv = '0; sen = 3'b001; saddr[0] = 5'd0; szero = 3'b000;
        tick();
        chk("r0_unforced_stall", obs_ready, 0);
        szero = 3'b001;
        tick();
        chk("r0_forced_ready", obs_ready, 1);
        chk("r0_forced_operand", operand[DATA_W-1:0], 0);

        // Two ports hit r9 in one cycle
        idle(); iv = 1; den = 1; daddr = 5'd9;
        repeat (2) tick();
        iv = 0; den = 0; dbga = 5'd9;
        wbv = 2'b11; wba[0] = 5'd9; wba[1] = 5'd9; wbd[0] = 64'h1; wbd[1] = 64'h2;
        tick();
        wbv = '0;
        tick();
        chk("dual_wb_data", dbg_data, 64'h2);
        iv = 1; sen = 3'b001; saddr[0] = 5'd9;
        tick();
        chk("dual_wb_drained", obs_ready, 1);
        chk("dual_wb_no_underflow", underflow, 0);

        // Underflow is sticky; reset clears it and clears dispatch at once
        idle(); wbv = 2'b01; wba[0] = 5'd4; wbd[0] = 64'h44;
        tick();
        chk("underflow_set", underflow, 1);
        wbv = '0;
        tick();
        chk("underflow_sticky", underflow, 1);
        iv = 1; dr = 0; tag = 32'hBEEF;
        tick();
        #2;
        reset_ni = 0;
        #1;
        chk("async_reset_valid", disp_valid, 0);
        chk("async_reset_underflow", underflow, 0);
        do_reset();
        wbv = 2'b01; wba[0] = 5'd0; wbd[0] = 64'h9;
        tick();
        chk("post_reset_wb_underflow", underflow, 1);

        // Randomized traffic on a small register window
        do_reset();
        for (int i = 0; i < 400; i++) begin
            iv = ($urandom_range(3) != 0);
            for (int k = 0; k < NUM_SRC; k++) begin
                sen[k]   = 1'($urandom_range(1));
                szero[k] = 1'($urandom_range(1));
                saddr[k] = REG_AW'($urandom_range(7));
            end
            den   = 1'($urandom_range(1));
            daddr = REG_AW'($urandom_range(7));
            tag   = $urandom;
            dr    = ($urandom_range(3) != 0);
            for (int p = 0; p < NUM_WB; p++) begin
                wbv[p] = ($urandom_range(2) == 0);
                wba[p] = REG_AW'($urandom_range(7));
                wbd[p] = {$urandom, $urandom};
            end
            dbga = REG_AW'($urandom_range(7));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/scoreboard_reg_unit.md
Name: scoreboard_reg_unit

Overview:
- Parametrised successor to the fixed-point register unit.
- N-entry register file with per-register pending-write counters, so several writes to one register can be in flight (WAW).
- Configurable number of source operands and writeback ports; valid/ready on both the issue and dispatch sides.
- Sits between decode/issue and the functional units; completed results return on the writeback ports.

Parameters:
- DATA_W, 64, register width in bits
- NUM_REGS, 32, number of architectural registers
- REG_AW, 5, register address width (clog2 NUM_REGS)
- NUM_SRC, 3, source operands per instruction
- NUM_WB, 2, writeback ports
- CNT_W, 2, pending-counter width; max in-flight writes per register = 2^CNT_W-1
- TAG_W, 32, opaque instruction payload passed through (opcode, format, unit code, address)

Ports:
- clock_i in 1 clock
- reset_ni in 1 asynchronous active-low reset
- issue_valid_i in 1 instruction offered
- issue_ready_o out 1 instruction accepted this cycle
- src_en_i in NUM_SRC operand k used
- src_addr_i in NUM_SRC*REG_AW operand k register, slice k
- src_zero_i in NUM_SRC operand k reads as 0 when its address is 0
- dst_en_i in 1 instruction writes a register
- dst_addr_i in REG_AW destination register
- tag_i in TAG_W payload
- disp_valid_o out 1 dispatch valid
- disp_ready_i in 1 functional unit accepts
- operand_o out NUM_SRC*DATA_W operand values
- src_en_o out NUM_SRC registered src_en_i
- dst_en_o out 1
- dst_addr_o out REG_AW
- tag_o out TAG_W
- wb_valid_i in NUM_WB writeback strobe
- wb_addr_i in NUM_WB*REG_AW
- wb_data_i in NUM_WB*DATA_W
- dbg_addr_i in REG_AW debug read address
- dbg_data_o out DATA_W registered debug read
- wb_underflow_o out 1 sticky: writeback arrived for a register whose counter was 0

Behaviour:
- Reset (async assert, sync deassert inside the block):
  - register file, counters, disp_valid_o, all dispatch outputs, dbg_data_o and wb_underflow_o go to 0.
- Source hazard on operand k: src_en[k] && !(src_zero[k] && addr==0) && cnt[addr] != 0.
- Destination saturation: dst_en_i && cnt[dst] == 2^CNT_W-1.
- Output stage free: !disp_valid_o || disp_ready_i.
- issue_ready_o = output stage free && no source hazard && no destination saturation.
  - Combinational; it may depend on issue_valid_i's companion fields but not on issue_valid_i itself.
- Accept = issue_valid_i && issue_ready_o.
  - On accept, operands, tag and dst are registered to the outputs next edge; disp_valid_o <= 1. Latency is 1 cycle.
  - Operand value is 0 when zero-forced or when src_en is 0, else regfile[addr].
- Output holding: if disp_valid_o && !disp_ready_i, all dispatch outputs hold stable. If disp_ready_i and no accept, disp_valid_o <= 0.
- Counter update per register r: cnt_next = cnt + (accept && dst_en && dst==r) − (number of wb ports hitting r whose cnt > 0). Issue and writeback to the same register in one cycle leave it unchanged.
- Writeback data:
  - Always written, even on underflow; underflow sets wb_underflow_o, which stays set until reset.
  - Several wb ports to the same address: the highest port index wins the data; every port decrements the counter.
- Read after write, base behaviour: a register whose last writeback lands in cycle t becomes readable for issue in t+1. No combinational wb→operand path.
- dbg_data_o <= regfile[dbg_addr_i] every cycle.
- Reset mid-operation clears all counters; in-flight writebacks arriving afterwards set wb_underflow_o.

Optional Feature:
- Macro: SCOREBOARD_REG_UNIT_BYPASS_EN.
- Defined: if cnt[addr]==1 and a wb port hits addr this cycle, the hazard is cleared and operand_o takes that wb_data_i (highest index). Zero-cycle RAW penalty.
- Undefined: no bypass; behaviour as in Behaviour, i.e. one stall cycle.

Decomposition:
- Shared package reg_unit_pkg:
  - use-code constants (IMM/READ/WRITE/READWRITE)
  - functional unit codes
  - default widths
- One sub-module: pending_counter_bank (NUM_REGS counters, issue increment, NUM_WB decrements, saturation/zero flags).

Test Plan:
- Reset, then issue src r3, dst r5 with disp_ready_i=1 → disp_valid_o high next cycle, operand 0, cnt[5]=1; r5 source next cycle → issue_ready_o=0.
- wb r5=0xDEAD in cycle t, r5 source offered at t → without macro, accepted t+1 with 0xDEAD; with macro, accepted t with operand 0xDEAD.
- Three issues to dst r7 with CNT_W=2 → fourth stalls (saturated); one wb r7 → fourth accepted; cnt returns to 0 only after three more wbs.
- disp_ready_i=0 for 4 cycles with valid output → outputs stable, issue_ready_o=0; release → next instruction dispatches the following cycle.
- src_zero on r0 with cnt[0]=1 → no stall, operand 0; wb ports 0 and 1 both write r9 (0x1, 0x2) → regfile r9=0x2, cnt decremented by 2.
- wb to r4 with cnt 0 → wb_underflow_o=1 and stays 1; assert reset_ni low mid-dispatch → disp_valid_o=0 immediately.
